// File: rtl/viper_pkg.sv
// Shared types and constants for the VIPER main-memory arbiter.
package viper_pkg;

    localparam int unsigned VIPER_AW = 20;
    localparam int unsigned VIPER_DW = 32;

    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_DATA  = 2'd1;
    localparam logic [1:0] REQ_DMA   = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RESP_OK  = 2'd2,
        RESP_ERR = 2'd3
    } state_e;

    // Next requester index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= REQ_DMA) ? REQ_FETCH : idx + 2'd1;
    endfunction

endpackage

// File: rtl/viper_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant, with wrap.
module viper_rr_pick
    import viper_pkg::*;
(
    input  logic [2:0] i_valid,
    input  logic [1:0] i_last_grant,
    output logic [1:0] o_winner,
    output logic       o_any_valid
);

    logic [1:0] w_cand0;
    logic [1:0] w_cand1;
    logic [1:0] w_cand2;

    assign w_cand0 = rr_next(i_last_grant);
    assign w_cand1 = rr_next(w_cand0);
    assign w_cand2 = rr_next(w_cand1);

    always_comb begin
        o_any_valid = |i_valid;
        o_winner    = w_cand2;
        if (i_valid[w_cand0]) begin
            o_winner = w_cand0;
        end else if (i_valid[w_cand1]) begin
            o_winner = w_cand1;
        end
    end

endmodule

// File: rtl/viper_mem_arbiter.sv
// Three-way round-robin arbiter for the single-ported VIPER memory bus, with a
// per-access timeout that reports a fault to the owning requester.
module viper_mem_arbiter
    import viper_pkg::*;
#(
    parameter int unsigned AW      = VIPER_AW,
    parameter int unsigned DW      = VIPER_DW,
    parameter int unsigned TIMEOUT = 16    // legal range 2..255
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [2:0]      req_valid,
    input  logic [2:0]      req_we,
    input  logic [3*AW-1:0] req_addr,
    input  logic [3*DW-1:0] req_wdata,
    output logic [2:0]      done,
    output logic [2:0]      err,
    output logic [DW-1:0]   rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e        r_state;
    logic [1:0]    r_last_grant;
    logic [1:0]    r_owner;
    logic [7:0]    r_cnt;
    logic [2:0]    r_done;
    logic [2:0]    r_err;
    logic [DW-1:0] r_rdata;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic [1:0]    w_winner;
    logic          w_any_valid;
    logic          w_we_sel;
    logic [AW-1:0] w_addr_sel;
    logic [DW-1:0] w_wdata_sel;
    logic [2:0]    w_owner_oh;

    viper_rr_pick u_rr_pick (
        .i_valid      (req_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any_valid  (w_any_valid)
    );

    always_comb begin
        w_we_sel    = req_we[0];
        w_addr_sel  = req_addr[0 +: AW];
        w_wdata_sel = req_wdata[0 +: DW];
        case (w_winner)
            REQ_DATA: begin
                w_we_sel    = req_we[1];
                w_addr_sel  = req_addr[AW +: AW];
                w_wdata_sel = req_wdata[DW +: DW];
            end
            REQ_DMA: begin
                w_we_sel    = req_we[2];
                w_addr_sel  = req_addr[2*AW +: AW];
                w_wdata_sel = req_wdata[2*DW +: DW];
            end
            default: ;
        endcase
    end

    assign w_owner_oh = 3'b001 << r_owner;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_DMA;
            r_owner      <= REQ_FETCH;
            r_cnt        <= '0;
            r_done       <= '0;
            r_err        <= '0;
            r_rdata      <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_owner     <= w_winner;
                        r_mem_we    <= w_we_sel;
                        r_mem_addr  <= w_addr_sel;
                        r_mem_wdata <= w_wdata_sel;
                        r_mem_req   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack on the final timeout cycle still counts as success.
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_last_grant <= r_owner;
                        r_state      <= RESP_OK;
                    end else if (r_cnt == CNT_LAST) begin
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_last_grant <= r_owner;
                        r_state      <= RESP_ERR;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP_OK: begin
                    r_done  <= w_owner_oh;
                    r_state <= IDLE;
                end
                RESP_ERR: begin
                    r_done  <= w_owner_oh;
                    r_err   <= w_owner_oh;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
